// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter for three writeback sources.
// Round-robin grant, registered WE3/A3/WD3, pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  stall,
  input  logic                  req0_valid,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  input  logic                  req2_valid,
  input  logic [ADDR_W-1:0]     req2_addr,
  input  logic [DATA_W-1:0]     req2_data,
  output logic                  req2_ready,
  input  logic                  alloc_valid,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic [2**ADDR_W-1:0]  pend_mask,
  output logic                  WE3,
  output logic [ADDR_W-1:0]     A3,
  output logic [DATA_W-1:0]     WD3,
  output logic                  pc_wr_drop
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

  logic [2:0]        vld;
  logic [2:0]        rot;
  logic [2:0]        rg;
  logic [2:0]        gnt;
  logic [1:0]        rr_ptr;
  logic [1:0]        nxt_ptr;
  logic              any;
  logic              is_pc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   set_m;
  logic [NREG-1:0]   clr_m;

  assign vld = {req2_valid, req1_valid, req0_valid};

  // Rotate valids so rr_ptr is bit 0, pick first, rotate back.
  always_comb begin
    rot = vld;
    case (rr_ptr)
      2'd1:    rot = {vld[0], vld[2], vld[1]};
      2'd2:    rot = {vld[1], vld[0], vld[2]};
      default: rot = vld;
    endcase
    rg = 3'b000;
    if (RST_N && !stall) begin
      if (rot[0])      rg = 3'b001;
      else if (rot[1]) rg = 3'b010;
      else if (rot[2]) rg = 3'b100;
    end
    case (rr_ptr)
      2'd1:    gnt = {rg[1], rg[0], rg[2]};
      2'd2:    gnt = {rg[0], rg[2], rg[1]};
      default: gnt = rg;
    endcase
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign req2_ready = gnt[2];
  assign any        = |gnt;

  // Mux the winning request and compute the next pointer.
  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    nxt_ptr  = rr_ptr;
    unique case (1'b1)
      gnt[0]: begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        nxt_ptr  = 2'd1;
      end
      gnt[1]: begin
        sel_addr = req1_addr;
        sel_data = req1_data;
        nxt_ptr  = 2'd2;
      end
      gnt[2]: begin
        sel_addr = req2_addr;
        sel_data = req2_data;
        nxt_ptr  = 2'd0;
      end
      default: ;
    endcase
  end

  assign is_pc = (sel_addr == PC_A);

  // Scoreboard set/clear masks; set wins over clear.
  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (alloc_valid && alloc_addr != PC_A)
      set_m[alloc_addr] = 1'b1;
    if (any && !is_pc)
      clr_m[sel_addr] = 1'b1;
  end

  // Arbitration pointer advances past the last winner.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rr_ptr <= 2'd0;
    else        rr_ptr <= nxt_ptr;
  end

  // Register-file write port; A3/WD3 hold when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WE3        <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
      pc_wr_drop <= 1'b0;
    end else begin
      WE3        <= any && !is_pc;
      pc_wr_drop <= any && is_pc;
      if (any && !is_pc) begin
        A3  <= sel_addr;
        WD3 <= sel_data;
      end
    end
  end

  // Pending-write scoreboard.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pend_mask <= '0;
    else        pend_mask <= (pend_mask & ~clr_m) | set_m;
  end

endmodule
